// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches over a req/valid handshake and holds
// the IR until acknowledged. Define FETCH_ILLEGAL_TRAP_EN to halt on unsupported opcodes.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              branch_taken,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              illegal_op
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalt} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4_q, pc_inc, branch_off;
    logic [31:0]       ir_q;
    logic              imem_req_q, ir_valid_q;
    logic              load_ir, redirect, bad_op;

`ifdef FETCH_ILLEGAL_TRAP_EN
    always_comb begin
        case (imem_rdata[31:26])
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001111: bad_op = 1'b0;
            default:                                                bad_op = 1'b1;
        endcase
    end
`else
    assign bad_op = 1'b0;
`endif

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= (state_d == StFetch);
            ir_valid_q <= (state_d == StHold);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (imem_valid) state_d = bad_op ? StHalt : StHold;
            StHold:  if (ir_ack) state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_ir    = (state_q == StFetch) && imem_valid;
        redirect   = (state_q == StHold) && ir_ack && branch_taken;
        pc_inc     = pc_q + ADDR_W'(4);
        branch_off = ADDR_W'($signed({ir_q[15:0], 2'b00}));
        pc_d       = pc_q;
        if (load_ir) begin
            pc_d = pc_inc;
        end else if (redirect) begin
            pc_d = pc_plus4_q + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + ADDR_W'(4);
            ir_q       <= '0;
        end else begin
            pc_q <= pc_d;
            if (load_ir) begin
                ir_q       <= imem_rdata;
                pc_plus4_q <= pc_inc;
            end
        end
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (state_d == StHalt);
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign ir_valid  = ir_valid_q;
    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign imm16     = ir_q[15:0];
    assign pc_plus4  = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: latency-configurable memory model plus a PC-level
// reference model driven by randomized latency, stalls and branch decisions.
module tb_instr_fetch_unit;
    localparam int unsigned AW  = 32;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_valid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        ir_valid, ir_ack = 1'b0, branch_taken = 1'b0;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] pc_plus4;
    logic        illegal_op;

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .ir_valid(ir_valid),
        .ir_ack(ir_ack), .branch_taken(branch_taken), .op(op), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .imm16(imm16), .pc_plus4(pc_plus4), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int req_cnt = 0;
    bit spurious = 1'b0;
    logic [31:0] ovr [logic [31:0]];

    // Memory contents: directed overrides, else a hash with a supported opcode.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] h;
        logic [5:0]  o;
        if (ovr.exists(a)) return ovr[a];
        h = (a ^ 32'h5bd1e995) * 32'h9e3779b1;
        h = h ^ (h >> 15);
        case (int'(h[31:28]) % 5)
            0:       o = 6'b000000;
            1:       o = 6'b100011;
            2:       o = 6'b101011;
            3:       o = 6'b000100;
            default: o = 6'b001111;
        endcase
        return {o, h[25:0]};
    endfunction

    function automatic logic [42:0] fields_of(input logic [31:0] w);
        return {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]};
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                            input bit bt);
        int signed off;
        off = int'($signed(w[15:0])) * 4;
        return bt ? pc + 32'd4 + 32'(off) : pc + 32'd4;
    endfunction

    // One clock; memory answers in the lat-th cycle that imem_req is seen high.
    task automatic tick();
        bit r;
        r = rst;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        if (r) begin
            req_cnt = 0;
        end else if (imem_req) begin
            req_cnt++;
            if (req_cnt >= lat) begin
                imem_valid = 1'b1;
                imem_rdata = word_at(imem_addr);
                req_cnt    = 0;
            end
        end else begin
            req_cnt = 0;
            if (spurious && $urandom_range(0, 1) == 1) begin
                imem_valid = 1'b1;
                imem_rdata = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Runs until a response is delivered; returns one cycle after the imem_valid cycle.
    task automatic fetch_obs(input logic [31:0] exp_pc, output logic [31:0] w, output int nreq,
                             output bit addr_ok, output bit tmo);
        bit done;
        done = 0; w = '0; nreq = 0; addr_ok = 1; tmo = 1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (imem_req) begin
                nreq++;
                if (imem_addr !== exp_pc) addr_ok = 0;
            end
            if (imem_valid) begin
                w = imem_rdata; done = 1; tmo = 0;
            end
            tick();
        end
    endtask

    task automatic ack(input bit bt);
        ir_ack = 1'b1;
        branch_taken = bt;
        tick();
        ir_ack = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic walk_to(input logic [31:0] target);
        logic [31:0] pc, w;
        int nreq;
        bit aok, tmo;
        pc = RPC;
        for (int i = 0; i < 64 && pc != target; i++) begin
            fetch_obs(pc, w, nreq, aok, tmo);
            ack(1'b0);
            pc = pc + 32'd4;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({imem_req, ir_valid, illegal_op} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {imem_req, ir_valid, illegal_op});
        end
        n_tests++;
        if ({imem_addr, pc_plus4, op, imm16} !== {RPC, RPC + 32'd4, 6'd0, 16'd0}) begin
            n_fail++; $display("FAIL reset_regs: got addr %h pc4 %h op %h imm %h", imem_addr,
                               pc_plus4, op, imm16);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, RPC}) begin
            n_fail++; $display("FAIL reset_to_fetch: got req %b addr %h want 1 %h", imem_req,
                               imem_addr, RPC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] w, pc;
        int nreq;
        bit aok, tmo;
        pc = RPC;
        for (int k = 0; k < 3; k++) begin
            fetch_obs(pc, w, nreq, aok, tmo);
            n_tests++;
            if ({tmo, aok, ir_valid} !== 3'b011) begin
                n_fail++; $display("FAIL seq_fetch%0d: got tmo/addr_ok/ir_valid %b want 011", k,
                                   {tmo, aok, ir_valid});
            end
            n_tests++;
            if (op !== word_at(pc) >> 26) begin
                n_fail++; $display("FAIL seq_op%0d: got %b want %b", k, op, word_at(pc) >> 26);
            end
            ack(1'b0);
            n_tests++;
            if ({ir_valid, imem_req, imem_addr} !== {2'b01, pc + 32'd4}) begin
                n_fail++; $display("FAIL seq_ack%0d: got v %b req %b addr %h want 0 1 %h", k,
                                   ir_valid, imem_req, imem_addr, pc + 32'd4);
            end
            pc = pc + 32'd4;
        end
    endtask

    task automatic test_latency();
        logic [31:0] w;
        int nreq;
        bit aok, tmo;
        ovr[32'h0] = 32'h8C220008;
        lat = 5;
        do_reset();
        fetch_obs(32'h0, w, nreq, aok, tmo);
        n_tests++;
        if (nreq != 5 || !aok || tmo) begin
            n_fail++; $display("FAIL lat_req: got %0d req cycles addr_ok %b tmo %b want 5 1 0",
                               nreq, aok, tmo);
        end
        n_tests++;
        if ({ir_valid, op, rs, rt, imm16, pc_plus4} !==
            {1'b1, 6'b100011, 5'd1, 5'd2, 16'h0008, 32'h4}) begin
            n_fail++; $display("FAIL lat_fields: got v %b op %b rs %0d rt %0d imm %h pc4 %h",
                               ir_valid, op, rs, rt, imm16, pc_plus4);
        end
    endtask

    task automatic test_hold_stall();
        logic [31:0] w;
        w = word_at(32'h0);
        spurious = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if ({ir_valid, imem_req, op, rs, rt, rd, funct, imm16, pc_plus4} !==
                {2'b10, fields_of(w), 32'h4}) begin
                n_fail++; $display("FAIL hold_stable%0d: got v %b req %b op %b imm %h pc4 %h", k,
                                   ir_valid, imem_req, op, imm16, pc_plus4);
            end
        end
        spurious = 1'b0;
        ack(1'b0);
    endtask

    task automatic test_branch();
        logic [31:0] w, tgt;
        int nreq;
        bit aok, tmo;
        lat = 1;
        for (int k = 0; k < 2; k++) begin
            ovr[32'h10] = (k == 0) ? {6'b000100, 5'd1, 5'd2, 16'hFFFC} :
                                     {6'b000100, 5'd1, 5'd2, 16'h0003};
            tgt = (k == 0) ? 32'h4 : 32'h20;
            do_reset();
            walk_to(32'h10);
            fetch_obs(32'h10, w, nreq, aok, tmo);
            n_tests++;
            if ({tmo, aok, op, pc_plus4} !== {2'b01, 6'b000100, 32'h14}) begin
                n_fail++; $display("FAIL beq_hold%0d: got tmo %b aok %b op %b pc4 %h", k, tmo,
                                   aok, op, pc_plus4);
            end
            ack(1'b1);
            n_tests++;
            if ({imem_req, imem_addr} !== {1'b1, tgt}) begin
                n_fail++; $display("FAIL beq_target%0d: got req %b addr %h want 1 %h", k,
                                   imem_req, imem_addr, tgt);
            end
        end
        ovr.delete(32'h10);
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        int nreq;
        bit aok, tmo;
        ovr[32'h0] = {6'b000100, 10'd0, 16'hFFFE};
        do_reset();
        fetch_obs(32'h0, w, nreq, aok, tmo);
        ack(1'b1);
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL wrap_branch: got req %b addr %h want 1 fffffffc", imem_req,
                               imem_addr);
        end
        fetch_obs(32'hFFFF_FFFC, w, nreq, aok, tmo);
        n_tests++;
        if ({tmo, aok, pc_plus4, op, rs, rt, rd, funct, imm16} !==
            {2'b01, 32'h0, fields_of(word_at(32'hFFFF_FFFC))}) begin
            n_fail++; $display("FAIL wrap_fetch: got tmo %b aok %b pc4 %h op %b", tmo, aok,
                               pc_plus4, op);
        end
        ack(1'b0);
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wrap_inc: got req %b addr %h want 1 0", imem_req, imem_addr);
        end
        ovr.delete(32'h0);
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] w;
        int nreq;
        bit aok, tmo;
        lat = 5;
        do_reset();
        walk_to(32'h40);
        tick();
        n_tests++;
        if ({imem_req, ir_valid, imem_addr} !== {2'b10, 32'h40}) begin
            n_fail++; $display("FAIL midrst_pending: got req %b v %b addr %h want 1 0 40",
                               imem_req, ir_valid, imem_addr);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({imem_req, ir_valid, imem_addr} !== {2'b00, RPC}) begin
            n_fail++; $display("FAIL midrst_idle: got req %b v %b addr %h want 0 0 %h",
                               imem_req, ir_valid, imem_addr, RPC);
        end
        rst = 1'b0;
        fetch_obs(RPC, w, nreq, aok, tmo);
        n_tests++;
        if ({tmo, aok, w, ir_valid} !== {2'b01, word_at(RPC), 1'b1} || nreq != 5) begin
            n_fail++; $display("FAIL midrst_refetch: got tmo %b aok %b word %h nreq %0d v %b",
                               tmo, aok, w, nreq, ir_valid);
        end
        lat = 1;
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        int nreq;
        bit aok, tmo, quiet;
        ovr[32'h0] = {6'b000010, 26'h0123456};
        do_reset();
        fetch_obs(32'h0, w, nreq, aok, tmo);
`ifdef FETCH_ILLEGAL_TRAP_EN
        n_tests++;
        if ({tmo, illegal_op, ir_valid, imem_req, op} !== {4'b0100, 6'b000010}) begin
            n_fail++; $display("FAIL illegal_trap: got tmo %b ill %b v %b req %b op %b", tmo,
                               illegal_op, ir_valid, imem_req, op);
        end
        quiet = 1;
        for (int k = 0; k < 10; k++) begin
            ir_ack = k[0];
            branch_taken = k[1];
            tick();
            if ({imem_req, ir_valid, illegal_op} !== 3'b001) quiet = 0;
        end
        ir_ack = 1'b0;
        branch_taken = 1'b0;
        n_tests++;
        if (!quiet) begin
            n_fail++; $display("FAIL illegal_halt: got left HALT want stay until rst");
        end
        do_reset();
        n_tests++;
        if (illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL illegal_clear: got %b want 0", illegal_op);
        end
`else
        quiet = 1;
        n_tests++;
        if ({tmo, illegal_op, ir_valid, op} !== {3'b001, 6'b000010} || !quiet) begin
            n_fail++; $display("FAIL illegal_pass: got tmo %b ill %b v %b op %b", tmo,
                               illegal_op, ir_valid, op);
        end
`endif
        ovr.delete(32'h0);
    endtask

    task automatic test_random();
        logic [31:0] pc, w;
        int nreq;
        bit aok, tmo, bt;
        ovr.delete();
        lat = 1;
        do_reset();
        pc = RPC;
        for (int k = 0; k < 40; k++) begin
            fetch_obs(pc, w, nreq, aok, tmo);
            n_tests++;
            if ({tmo, aok, ir_valid, op, rs, rt, rd, funct, imm16, pc_plus4} !==
                {3'b011, fields_of(word_at(pc)), pc + 32'd4}) begin
                n_fail++; $display("FAIL rand%0d: pc %h got tmo %b aok %b v %b op %b imm %h pc4 %h",
                                   k, pc, tmo, aok, ir_valid, op, imm16, pc_plus4);
            end
            for (int s = $urandom_range(0, 3); s > 0; s--) tick();
            bt  = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 4);
            ack(bt);
            pc = next_pc(pc, word_at(pc), bt);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_latency();
        test_hold_stall();
        test_branch();
        test_wrap();
        test_reset_mid_fetch();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch stage. Produces the opcode and instruction fields consumed by the main control decoder and the register file.
- Owns the PC and fetches 32-bit words from instruction memory over a req/valid handshake.
- Holds each instruction in an IR until the execute side acknowledges it.
- Applies beq redirects (Branch & Zero) at acknowledge time.

Parameters:
ADDR_W, 32, byte-address width of PC and imem_addr; PC arithmetic wraps modulo 2^ADDR_W
RESET_PC, 0, PC value loaded on reset; must be word-aligned

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request, registered
imem_addr  output  ADDR_W  byte address of requested word (= PC), bits [1:0] always 0
imem_rdata  input  32  instruction word, sampled only when imem_valid=1 in FETCH
imem_valid  input  1  memory response strobe, 1 cycle, any latency >= 1 cycle after req
ir_valid  output  1  IR holds an unconsumed instruction
ir_ack  input  1  execute side consumes IR this cycle
branch_taken  input  1  Branch & Zero for the held instruction, sampled with ir_ack
op  output  6  IR[31:26]
rs  output  5  IR[25:21]
rt  output  5  IR[20:16]
rd  output  5  IR[15:11]
funct  output  6  IR[5:0]
imm16  output  16  IR[15:0]
pc_plus4  output  ADDR_W  address of held instruction + 4
illegal_op  output  1  unsupported opcode trap flag (see Optional Feature)

Behaviour:
- States: IDLE, FETCH, HOLD, HALT.
- Reset (synchronous, dominant over everything, any state):
  - state=IDLE, PC=RESET_PC, IR=0, pc_plus4=RESET_PC+4.
  - imem_req=0, ir_valid=0, illegal_op=0.
  - Any in-flight memory response is abandoned. Memory shares rst and drops it.
- IDLE: next cycle -> FETCH, imem_req<=1.
- FETCH:
  - imem_req=1, imem_addr=PC. Request is held high until imem_valid.
  - On imem_valid: IR<=imem_rdata, pc_plus4<=PC+4, PC<=PC+4, imem_req<=0, ir_valid<=1 -> HOLD.
  - Latency from imem_valid to ir_valid=1 is 1 cycle.
- HOLD:
  - ir_valid=1. IR and field outputs are stable.
  - Without ir_ack: stay in HOLD; a spurious imem_valid is ignored.
  - ir_ack & !branch_taken: PC unchanged (already +4) -> FETCH.
  - ir_ack & branch_taken: PC<=pc_plus4 + (sign_extend(imm16)<<2), truncated to ADDR_W -> FETCH.
  - On ack, ir_valid<=0 and imem_req<=1 in the same edge. New request is visible the cycle after ack; minimum 1 bubble.
- branch_taken and ir_ack are ignored outside HOLD. imem_valid is ignored outside FETCH.
- Field outputs are pure slices of IR; stale fields after ack are don't-care while ir_valid=0.
- Wrap: PC=2^ADDR_W-4 increments to 0; branch target arithmetic wraps identically.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - When an instruction is latched in FETCH, it is checked against the supported opcodes {000000, 100011, 101011, 000100, 001111}.
  - Unsupported opcode -> state HALT instead of HOLD, illegal_op<=1, ir_valid<=0, imem_req<=0. IR keeps the bad word for debug.
  - HALT exits only on rst; ir_ack is ignored in HALT.
- Not defined: no opcode check, HALT unreachable, illegal_op tied 0.

Test Plan:
- Reset then 1-cycle memory, RESET_PC=0, ack every HOLD -> imem_addr sequence 0x0, 0x4, 0x8; ir_valid rises 1 cycle after each imem_valid; op matches word[31:26].
- Memory latency 5 cycles, word 0x8C220008 (lw) -> imem_req high 5 cycles at addr 0x0; op=100011, rs=1, rt=2, imm16=0x0008, pc_plus4=0x4.
- ir_ack withheld 10 cycles in HOLD with spurious imem_valid pulses -> outputs stable, no new request, IR unchanged.
- beq at 0x10, imm16=0xFFFC, ack with branch_taken=1 -> next imem_addr=0x4; imm16=0x0003 from the same PC -> next imem_addr=0x20.
- rst asserted mid-FETCH at PC=0x40 with response pending -> next cycle IDLE, ir_valid=0, imem_req=0; then FETCH at RESET_PC.
- FETCH_ILLEGAL_TRAP_EN defined, word op=000010 -> illegal_op=1, ir_valid=0, no further requests until rst. Undefined: same word -> ir_valid=1, op=000010, illegal_op=0.
